// File: rtl/fir_lut_loader_if.sv
// rtl/fir_lut_loader_if.sv - coefficient/command and LUT load signal bundle for fir_lut_loader
interface fir_lut_loader_if #(
    parameter int COEF_W = 16,
    parameter int LUT_W  = 19,
    parameter int ADDR_W = 11,
    parameter int TAP_AW = 6
);
    logic                     coef_we;
    logic [TAP_AW-1:0]        coef_addr;
    logic signed [COEF_W-1:0] coef_din;
    logic                     start;
    logic signed [LUT_W-1:0]  CIN;
    logic [ADDR_W-1:0]        CADDR;
    logic                     CLOAD;
    logic                     fir_en;
    logic                     busy;
    logic                     done;
    logic                     coef_err;

    modport master (
        output coef_we, coef_addr, coef_din, start,
        input  CIN, CADDR, CLOAD, fir_en, busy, done, coef_err
    );

    modport slave (
        input  coef_we, coef_addr, coef_din, start,
        output CIN, CADDR, CLOAD, fir_en, busy, done, coef_err
    );
endinterface

// File: rtl/fir_lut_loader.sv
// rtl/fir_lut_loader.sv - holds 64 FIR coefficients and streams the 2048 DA partial-sum LUT entries
module fir_lut_loader #(
    parameter int COEF_W   = 16,
    parameter int NUM_TAPS = 64,
    parameter int GRP      = 8,
    parameter int LUT_W    = 19,
    parameter int ADDR_W   = 11
) (
    input logic            clk_slow,
    input logic            reset,
    fir_lut_loader_if.slave bus
);
    localparam int GRP_B = $clog2(GRP);

    typedef enum logic [1:0] {IDLE, GEN, RUN} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        idx_q;
    logic                     gen_last_q;
    logic signed [COEF_W-1:0] coef_q [NUM_TAPS];
    logic signed [LUT_W-1:0]  entry;
    logic signed [LUT_W-1:0]  cin_q;
    logic [ADDR_W-1:0]        caddr_q;
    logic                     cload_q;
    logic                     fir_en_q;
    logic                     done_q;
    logic                     coef_err_q;

    always_ff @(posedge clk_slow) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // gen_last marks the extra GEN cycle that lets entry 2047 leave the output register
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RUN: if (bus.start) state_d = GEN;
            GEN:       if (gen_last_q) state_d = RUN;
            default:   state_d = IDLE;
        endcase
    end

    // Selected group's 8 coefficients, sign-extended and summed where the pattern bit is set
    always_comb begin
        entry = '0;
        for (int b = 0; b < GRP; b++) begin
            if (idx_q[b])
                entry = entry + LUT_W'(coef_q[{idx_q[ADDR_W-1:GRP], GRP_B'(b)}]);
        end
    end

    always_ff @(posedge clk_slow) begin
        if (reset) begin
            idx_q      <= '0;
            gen_last_q <= 1'b0;
            cin_q      <= '0;
            caddr_q    <= '0;
            cload_q    <= 1'b0;
            fir_en_q   <= 1'b0;
            done_q     <= 1'b0;
            coef_err_q <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) coef_q[k] <= '0;
        end else begin
            cload_q <= 1'b0;
            done_q  <= 1'b0;
            if (bus.coef_we) begin
                if (state_q == GEN) coef_err_q <= 1'b1;
                else                coef_q[bus.coef_addr] <= bus.coef_din;
            end
            case (state_q)
                IDLE, RUN: begin
                    if (bus.start) begin
                        idx_q      <= '0;
                        gen_last_q <= 1'b0;
                        fir_en_q   <= 1'b0;
                    end
                end
                GEN: begin
                    if (!gen_last_q) begin
                        cin_q   <= entry;
                        caddr_q <= idx_q;
                        cload_q <= 1'b1;
                        if (idx_q == '1) gen_last_q <= 1'b1;
                        else             idx_q      <= idx_q + 1'b1;
                    end else begin
                        done_q   <= 1'b1;
                        fir_en_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.CIN      = cin_q;
    assign bus.CADDR    = caddr_q;
    assign bus.CLOAD    = cload_q;
    assign bus.fir_en   = fir_en_q;
    assign bus.busy     = (state_q == GEN);
    assign bus.done     = done_q;
    assign bus.coef_err = coef_err_q;
endmodule

// File: tb/tb_fir_lut_loader.sv
// tb/tb_fir_lut_loader.sv - directed table-driven bench for fir_lut_loader
module tb_fir_lut_loader;
    logic clk_slow = 1'b0;
    logic reset    = 1'b1;
    always #5 clk_slow = ~clk_slow;

    fir_lut_loader_if bus ();

    fir_lut_loader dut (
        .clk_slow (clk_slow),
        .reset    (reset),
        .bus      (bus)
    );

    typedef struct {
        int    pat;
        int    addr;
        int    exp;
        string name;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cap [2048];
    vec_t vecs [21];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_coef(input int addr, input int val);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 6'(addr);
        bus.coef_din  = 16'(val);
        @(negedge clk_slow);
        bus.coef_we   = 1'b0;
    endtask

    function automatic int nonzero_entries();
        int n = 0;
        for (int a = 0; a < 2048; a++) if (cap[a] != 0) n++;
        return n;
    endfunction

    // Start a load, capture every presented entry and check the cycle-exact framing
    task automatic gen(input bit we63, input int inj_we, input int inj_start);
        int n_load = 0, done_cnt = 0, serr = 0;
        for (int a = 0; a < 2048; a++) cap[a] = 32'h7fffffff;
        bus.start = 1'b1;
        if (we63) begin
            bus.coef_we   = 1'b1;
            bus.coef_addr = 6'd63;
            bus.coef_din  = 16'sd63;
        end
        @(negedge clk_slow);
        bus.start   = 1'b0;
        bus.coef_we = 1'b0;
        if (bus.busy !== 1'b1 || bus.CLOAD !== 1'b0) serr++;
        for (int cyc = 2; cyc <= 2053; cyc++) begin
            @(negedge clk_slow);
            bus.start   = 1'b0;
            bus.coef_we = 1'b0;
            if (bus.CLOAD !== (cyc <= 2049)) serr++;
            if (bus.busy !== (cyc <= 2049)) serr++;
            if (bus.done !== (cyc == 2050)) serr++;
            if (bus.fir_en !== (cyc >= 2050)) serr++;
            if (bus.CLOAD === 1'b1) begin
                n_load++;
                if (int'(bus.CADDR) != cyc - 2) serr++;
                cap[bus.CADDR] = int'(bus.CIN);
            end
            if (bus.done === 1'b1) done_cnt++;
            if (cyc == inj_we) begin
                bus.coef_we   = 1'b1;
                bus.coef_addr = 6'd5;
                bus.coef_din  = 16'sd7;
            end
            if (cyc == inj_start) bus.start = 1'b1;
        end
        check("gen_load_count", n_load, 2048);
        check("gen_done_count", done_cnt, 1);
        check("gen_framing_errs", serr, 0);
        check("gen_caddr_hold", int'(bus.CADDR), 2047);
        check("gen_fir_en_after", int'(bus.fir_en), 1);
    endtask

    task automatic prepare(input int pat);
        case (pat)
            0: begin
                gen(1'b0, -1, -1);
                check("zero_lut_nonzero", nonzero_entries(), 0);
            end
            1: begin
                for (int k = 0; k < 64; k++) write_coef(k, 1);
                gen(1'b0, -1, -1);
            end
            2: begin
                for (int k = 0; k < 64; k++) write_coef(k, -32768);
                gen(1'b0, -1, -1);
            end
            3: begin
                for (int k = 0; k < 64; k++) write_coef(k, 32767);
                gen(1'b0, -1, -1);
            end
            4: begin
                for (int k = 0; k < 63; k++) write_coef(k, k);
                write_coef(63, 0);
                gen(1'b1, -1, -1);
            end
            default: begin
                for (int k = 0; k < 64; k++) write_coef(k, k);
                check("coef_err_before", int'(bus.coef_err), 0);
                gen(1'b0, 10, 20);
                check("coef_err_after", int'(bus.coef_err), 1);
            end
        endcase
    endtask

    initial begin
        int cur = -1;
        int found = 0;
        int dcnt = 0;

        vecs[0]  = '{0, 'h0FF, 0, "zero_0ff"};
        vecs[1]  = '{0, 'h7FF, 0, "zero_7ff"};
        vecs[2]  = '{0, 'h555, 0, "zero_555"};
        vecs[3]  = '{1, 'h0FF, 8, "ones_0ff"};
        vecs[4]  = '{1, 'h105, 2, "ones_105"};
        vecs[5]  = '{1, 'h7FF, 8, "ones_7ff"};
        vecs[6]  = '{1, 'h000, 0, "ones_000"};
        vecs[7]  = '{1, 'h0A3, 4, "ones_0a3"};
        vecs[8]  = '{2, 'h0FF, -262144, "min_0ff"};
        vecs[9]  = '{2, 'h001, -32768, "min_001"};
        vecs[10] = '{2, 'h303, -65536, "min_303"};
        vecs[11] = '{3, 'h0FF, 262136, "max_0ff"};
        vecs[12] = '{3, 'h480, 32767, "max_480"};
        vecs[13] = '{4, 'h1FF, 92, "idx_1ff"};
        vecs[14] = '{4, 'h703, 113, "idx_703"};
        vecs[15] = '{4, 'h000, 0, "idx_000"};
        vecs[16] = '{4, 'h780, 63, "idx_780_we_with_start"};
        vecs[17] = '{4, 'h0FF, 28, "idx_0ff"};
        vecs[18] = '{5, 'h020, 5, "gen_we_ignored_020"};
        vecs[19] = '{5, 'h0FF, 28, "gen_we_ignored_0ff"};
        vecs[20] = '{5, 'h7FF, 476, "gen_we_ignored_7ff"};

        bus.start     = 1'b1;
        bus.coef_we   = 1'b1;
        bus.coef_addr = 6'd3;
        bus.coef_din  = 16'sh1234;
        reset         = 1'b1;
        repeat (3) @(negedge clk_slow);
        check("rst_cin", int'(bus.CIN), 0);
        check("rst_caddr", int'(bus.CADDR), 0);
        check("rst_flags", int'({bus.CLOAD, bus.fir_en, bus.busy, bus.done, bus.coef_err}), 0);
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.coef_we = 1'b0;
        @(negedge clk_slow);
        check("idle_busy", int'(bus.busy), 0);

        for (int i = 0; i < 21; i++) begin
            if (vecs[i].pat != cur) begin
                cur = vecs[i].pat;
                prepare(cur);
            end
            check(vecs[i].name, cap[vecs[i].addr], vecs[i].exp);
        end

        bus.start = 1'b1;
        @(negedge clk_slow);
        bus.start = 1'b0;
        for (int c = 0; c < 1100 && found == 0; c++) begin
            @(negedge clk_slow);
            if (bus.CLOAD === 1'b1 && bus.CADDR == 11'd1000) found = 1;
        end
        check("midgen_reach_1000", found, 1);
        reset = 1'b1;
        @(negedge clk_slow);
        reset = 1'b0;
        check("midgen_rst_flags", int'({bus.CLOAD, bus.busy, bus.fir_en, bus.done, bus.coef_err}), 0);
        repeat (6) begin
            @(negedge clk_slow);
            if (bus.done === 1'b1 || bus.CLOAD === 1'b1) dcnt++;
        end
        check("midgen_no_done", dcnt, 0);
        gen(1'b0, -1, -1);
        check("restart_addr0", cap[0], 0);
        check("restart_zero_lut", nonzero_entries(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_lut_loader.md
Name: fir_lut_loader

Overview:
Configuration controller for the 64-tap distributed-arithmetic fir_filter. It holds the 64 signed filter coefficients in a local register file. On command it computes all 2048 partial-sum LUT entries (8 groups × 256 bit patterns) and streams them into the filter over the CIN/CADDR/CLOAD port, one entry per clock. When the load completes it enables the filter's valid_in. It runs on the filter's sample clock, so it replaces the bench-side LUT precomputation.

Parameters:
COEF_W, 16, coefficient width (signed two's complement)
NUM_TAPS, 64, number of coefficients
GRP, 8, taps per DA group (LUT address bits per group)
LUT_W, 19, LUT entry width = COEF_W + log2(GRP)
ADDR_W, 11, LUT address width = log2(NUM_TAPS/GRP) + GRP

Ports:
clk_slow  in  1  sole clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
coef_we  in  1  write strobe for the coefficient file
coef_addr  in  6  coefficient index 0..63
coef_din  in  16  signed coefficient value
start  in  1  one-cycle request to generate and load the LUT
CIN  out  19  signed LUT entry value to fir_filter
CADDR  out  11  LUT address to fir_filter
CLOAD  out  1  LUT write enable to fir_filter
fir_en  out  1  drives fir_filter valid_in; high once LUT is loaded
busy  out  1  high while state is GEN
done  out  1  one-cycle pulse when the final entry has been presented
coef_err  out  1  sticky flag: coef_we was asserted while busy

Behaviour:
- Reset (sync, reset=1 at an edge): state=IDLE; counter=0; all 64 coefficients=0; CIN=0, CADDR=0, CLOAD=0, fir_en=0, busy=0, done=0, coef_err=0. Reset has priority over every other input, including mid-GEN.
- States:
  - IDLE: accepts coef_we.
  - GEN: 2048-cycle entry generation.
  - RUN: LUT loaded, fir_en=1, accepts coef_we.
- Coefficient writes: coef_we in IDLE or RUN writes coef[coef_addr] <= coef_din at that edge. coef_we in GEN is ignored and sets coef_err=1. coef_err clears only on reset.
- Coefficient writes in RUN do not modify the loaded LUT. A new start is required to reload it.
- start in IDLE or RUN: next state GEN, counter=0, fir_en<=0. start in GEN is ignored.
- start and coef_we in the same IDLE/RUN cycle: the write takes effect and is included in the generated LUT.
- GEN, entry computation: counter idx (11 bits) increments every cycle. Group g=idx[10:8], pattern n=idx[7:0]. entry = sum over b=0..7 of (n[b] ? coef[8g+b] : 0). Each coefficient is sign-extended to 19 bits before summing; the result is exact with no saturation.
- GEN, output register: one output register stage, so CIN, CADDR and CLOAD update together. CADDR=idx and CIN=entry(idx) appear with CLOAD=1 one cycle after idx is counted.
- Timing from start sampled at edge t:
  - busy=1 from t+1 through t+2049.
  - Entry i is presented (CLOAD=1) at cycles t+2..t+2049.
  - At t+2050: CLOAD=0, done=1 for one cycle, fir_en=1, state=RUN, busy=0.
- CLOAD is never high outside GEN. CADDR is monotonic 0..2047 with no gaps or repeats. CIN and CADDR hold their last values when CLOAD=0.
- Reset during GEN: the next cycle has CLOAD=0 and fir_en=0. No partial-load completion is signalled. A later start regenerates from address 0.
- Counter wrap: idx reaching 2047 ends GEN. It never wraps to 0 while CLOAD=1.
- Expected implementation: 8-way 19-bit adder tree on an 8:1 group mux (8 × 16-bit), counter, 3-state FSM, 64×16 register file.

Test Plan:
- Reset with start=1 and coef_we=1 held for 3 cycles -> all outputs 0, coef file all 0; after release, a start produces 2048 entries with CIN=0.
- coef[all]=1, start -> CLOAD high exactly 2048 consecutive cycles. CIN = popcount(CADDR[7:0]), e.g. CADDR 0x0FF -> 8, 0x105 -> 2, 0x7FF -> 8. done pulses once; fir_en=1 after.
- coef[all]=-32768 -> CADDR 0x0FF gives CIN=-262144 (19'h40000). coef[all]=32767 -> CADDR 0x0FF gives CIN=262136. No wrap at either extreme.
- coef[k]=k -> CADDR 0x1FF gives CIN=92 (8+…+15), 0x703 gives 113 (56+57), 0x000 gives 0.
- Reset asserted when CADDR=1000 -> next cycle CLOAD=0, busy=0, fir_en=0, done never pulses. A new start restarts at CADDR 0.
- coef_we during GEN (addr 5, value 7) -> coef_err=1, coef[5] unchanged in the streamed LUT. start mid-GEN -> sequence length still 2048, single done.
